sample_frame_collector: RTL and testbench

//  Upstream feeder for the 16-lane signed-sum datapath. Accepts a serial stream of signed
//  8-bit samples over a valid/ready handshake and packs NUM_LANES consecutive samples into
//  one parallel frame. Each frame is held stable, with frame_valid, until the summing stage

---
 rtl/sample_frame_collector.sv | 113 +++++++++++
 tb/tb_sample_frame_collector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_frame_collector.sv
// rtl/sample_frame_collector.sv - packs serial signed samples into double-banked parallel frames
module sample_frame_collector #(
    parameter int DATAWIDTH = 8,
    parameter int NUM_LANES = 16,
    parameter int CNTWIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATAWIDTH-1:0]           in_data,
    input  logic                           in_valid,
    input  logic                           in_sof,
    output logic                           in_ready,
    output logic [NUM_LANES*DATAWIDTH-1:0] frame_data,
    output logic                           frame_valid,
    input  logic                           frame_ready,
    output logic                           err_short,
    output logic [CNTWIDTH-1:0]            frame_count
);

    localparam int IDXW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_LANES - 1);

    typedef logic [NUM_LANES-1:0][DATAWIDTH-1:0] bank_t;

    logic [IDXW-1:0]     idx_q, idx_d;
    bank_t               cap_q, cap_d;
    bank_t               out_q, out_d;
    logic                cap_full_q, cap_full_d;
    logic                frame_valid_q, frame_valid_d;
    logic                err_short_q, err_short_d;
    logic [CNTWIDTH-1:0] frame_count_q, frame_count_d;

    logic accept;
    logic take;
    logic sof_restart;
    logic bank_free;

    assign in_ready    = ~cap_full_q;
    assign accept      = in_valid & in_ready;
    assign take        = frame_valid_q & frame_ready;
    assign sof_restart = accept & in_sof & (idx_q != '0);
    assign bank_free   = ~frame_valid_q | take;

    always_comb begin
        idx_d         = idx_q;
        cap_d         = cap_q;
        out_d         = out_q;
        cap_full_d    = cap_full_q;
        frame_valid_d = frame_valid_q;
        err_short_d   = 1'b0;
        frame_count_d = frame_count_q;

        if (take) begin
            frame_valid_d = 1'b0;
        end

        // A parked frame moves to the output on the take; accept is blocked meanwhile.
        if (cap_full_q && take) begin
            out_d         = cap_q;
            frame_valid_d = 1'b1;
            cap_full_d    = 1'b0;
            frame_count_d = frame_count_q + 1'b1;
        end

        if (accept) begin
            if (sof_restart) begin
                cap_d[0]    = in_data;
                idx_d       = IDXW'(1);
                err_short_d = 1'b1;
            end else begin
                cap_d[idx_q] = in_data;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (bank_free) begin
                        out_d         = cap_d;
                        frame_valid_d = 1'b1;
                        frame_count_d = frame_count_q + 1'b1;
                    end else begin
                        cap_full_d = 1'b1;
                    end
                end else begin
                    idx_d = IDXW'(idx_q + 1'b1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q         <= '0;
            cap_q         <= '0;
            out_q         <= '0;
            cap_full_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            err_short_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            idx_q         <= idx_d;
            cap_q         <= cap_d;
            out_q         <= out_d;
            cap_full_q    <= cap_full_d;
            frame_valid_q <= frame_valid_d;
            err_short_q   <= err_short_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_data  = out_q;
    assign frame_valid = frame_valid_q;
    assign err_short   = err_short_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_sample_frame_collector.sv
// tb/tb_sample_frame_collector.sv - directed self-checking bench for sample_frame_collector
module tb_sample_frame_collector;

    logic         clk;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_sof;
    logic         in_ready;
    logic [127:0] frame_data;
    logic         frame_valid;
    logic         frame_ready;
    logic         err_short;
    logic [15:0]  frame_count;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_a;
    logic [127:0] exp_b;
    int           sum;

    sample_frame_collector #(
        .DATAWIDTH(8),
        .NUM_LANES(16),
        .CNTWIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .err_short  (err_short),
        .frame_count(frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic sof);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("push_timeout", 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    function automatic int lane_sum(input logic [127:0] f);
        int s;
        s = 0;
        for (int k = 0; k < 16; k++) s += int'($signed(f[k*8 +: 8]));
        return s;
    endfunction

    initial begin
        rst         = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        in_sof      = 1'b0;
        frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        check("rst_in_ready", in_ready, 1'b1);
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_frame_data", frame_data, 128'h0);
        check("rst_err_short", err_short, 1'b0);
        check("rst_frame_count", frame_count, 16'd0);

        // 1: samples 1..16, downstream ready
        for (int i = 0; i < 16; i++) begin
            push(8'(i + 1), i == 0);
            exp_a[i*8 +: 8] = 8'(i + 1);
        end
        check("t1_valid", frame_valid, 1'b1);
        check("t1_data", frame_data, exp_a);
        sum = lane_sum(frame_data);
        check("t1_sum", 128'(sum), 128'(136));
        check("t1_count", frame_count, 16'd1);
        check("t1_ready", in_ready, 1'b1);
        step();
        check("t1_cleared", frame_valid, 1'b0);

        // 2: downstream stalled, two frames back-to-back
        frame_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            push(8'(8'h10 + i), (i % 16) == 0);
            if (i < 16) exp_a[i*8 +: 8] = 8'(8'h10 + i);
            else        exp_b[(i-16)*8 +: 8] = 8'(8'h10 + i);
            if (i == 15) begin
                check("t2_first_valid", frame_valid, 1'b1);
                check("t2_first_count", frame_count, 16'd2);
            end
            if (i < 31) check("t2_ready_open", in_ready, 1'b1);
        end
        check("t2_ready_low", in_ready, 1'b0);
        check("t2_hold_data", frame_data, exp_a);
        step();
        step();
        check("t2_hold_data2", frame_data, exp_a);
        check("t2_hold_valid", frame_valid, 1'b1);
        check("t2_hold_count", frame_count, 16'd2);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check("t2_swap_data", frame_data, exp_b);
        check("t2_swap_valid", frame_valid, 1'b1);
        check("t2_swap_count", frame_count, 16'd3);
        check("t2_swap_ready", in_ready, 1'b1);
        frame_ready = 1'b1;
        step();
        check("t2_cleared", frame_valid, 1'b0);

        // 3: in_sof on the 5th sample restarts the frame
        for (int i = 0; i < 4; i++) push(8'(i + 1), i == 0);
        check("t3_no_err_yet", err_short, 1'b0);
        push(8'h7F, 1'b1);
        check("t3_err_pulse", err_short, 1'b1);
        exp_a[7:0] = 8'h7F;
        for (int j = 1; j < 16; j++) begin
            push(8'(8'h50 + j), 1'b0);
            exp_a[j*8 +: 8] = 8'(8'h50 + j);
            if (j == 1) check("t3_err_single", err_short, 1'b0);
            if (j == 14) check("t3_not_yet", frame_valid, 1'b0);
        end
        check("t3_valid", frame_valid, 1'b1);
        check("t3_data", frame_data, exp_a);
        check("t3_count", frame_count, 16'd4);
        step();

        // 4: extreme values pass bit-exact
        for (int i = 0; i < 16; i++) begin
            exp_a[i*8 +: 8] = (i == 0) ? 8'h80 : (i == 15) ? 8'h7F : 8'hFF;
            push(exp_a[i*8 +: 8], i == 0);
        end
        check("t4_data", frame_data, exp_a);
        sum = lane_sum(frame_data);
        check("t4_sum", 128'(sum), 128'(-15));
        check("t4_count", frame_count, 16'd5);
        step();

        // 5: asynchronous reset mid-frame, with a frame held at the output
        frame_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(8'h01, i == 0);
        for (int i = 0; i < 9; i++) push(8'(8'h30 + i), i == 0);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_valid", frame_valid, 1'b0);
        check("t5_rst_data", frame_data, 128'h0);
        check("t5_rst_count", frame_count, 16'd0);
        check("t5_rst_err", err_short, 1'b0);
        check("t5_rst_ready", in_ready, 1'b1);
        frame_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h60 + i), i == 0);
            exp_a[i*8 +: 8] = 8'(8'h60 + i);
            if (i == 0) check("t5_sof_no_err", err_short, 1'b0);
        end
        check("t5_valid", frame_valid, 1'b1);
        check("t5_data", frame_data, exp_a);
        check("t5_count", frame_count, 16'd1);
        step();

        // 6: frame counter wraps
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        check("t6_preload", frame_count, 16'hFFFF);
        for (int i = 0; i < 16; i++) push(8'(i), i == 0);
        check("t6_valid", frame_valid, 1'b1);
        check("t6_wrap", frame_count, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
